pe_out_serializer: RTL



---
 rtl/pe_pkg.sv | 19 +
 rtl/pe_out_serializer.sv | 110 +++++++++++
 2 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: definitions shared by the readout PE output path.
//   WORDLEN_DEF  default result word width (16 bits)
//   ser_state_e  serializer FSM state (IDLE, SEND)
//   idx_w()      width of a word-index counter for n words
package pe_pkg;

   localparam int WORDLEN_DEF = 16;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_e;

   // Never returns zero, so a counter always has at least one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pe_out_serializer.sv
// pe_out_serializer: captures the full NWORDS-word PE result vector in a
// single load and streams it out one word per cycle, word 0 first, over a
// valid/ready handshake. The final word is flagged with dout_last.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ce           clock enable; all state holds while low
//   ld, q_in     load strobe and PE result vector (word i at [i*WORDLEN +: WORDLEN])
//   ld_rdy       a load is accepted this cycle (combinational on dout_rdy)
//   dout         current word
//   dout_vld     dout is valid
//   dout_rdy     downstream accepts dout
//   dout_last    dout is word NWORDS-1
//   busy         a vector is being drained
//   ovf          sticky flag: a load arrived while not ready and was dropped
//   dout_par     even parity of dout (present only with PE_OUT_PARITY_EN)
//
// Build option: define PE_OUT_PARITY_EN to add the dout_par port and logic.
module pe_out_serializer
   import pe_pkg::*;
#(
   parameter int WORDLEN = WORDLEN_DEF,
   parameter int NWORDS  = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ce,
   input  logic                      ld,
   input  logic [WORDLEN*NWORDS-1:0] q_in,
   output logic                      ld_rdy,
   output logic [WORDLEN-1:0]        dout,
   output logic                      dout_vld,
   input  logic                      dout_rdy,
   output logic                      dout_last,
   output logic                      busy,
`ifdef PE_OUT_PARITY_EN
   output logic                      dout_par,
`endif
   output logic                      ovf
);

   localparam int             IW       = idx_w(NWORDS);
   localparam logic [IW-1:0]  LAST_IDX = IW'(NWORDS - 1);

   ser_state_e                          state_q, state_d;
   logic [IW-1:0]                       idx_q, idx_d;
   logic [NWORDS-1:0][WORDLEN-1:0]      buf_q, buf_d;
   logic                                ovf_q, ovf_d;

   logic is_last, xfer, accept;

   assign busy      = (state_q == SEND);
   assign dout_vld  = busy;
   assign is_last   = (idx_q == LAST_IDX);
   // Gated by busy so an idle block never advertises a last word.
   assign dout_last = busy & is_last;
   assign dout      = buf_q[idx_q];

   // Ready while idle, or on the cycle the final word leaves, so a new
   // vector can follow the previous one without a bubble.
   assign ld_rdy = ~busy | (dout_vld & dout_rdy & dout_last);
   assign xfer   = ce & dout_vld & dout_rdy;
   assign accept = ce & ld & ld_rdy;

`ifdef PE_OUT_PARITY_EN
   assign dout_par = ^dout;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      ovf_d   = ovf_q;

      if (ce & ld & ~ld_rdy) ovf_d = 1'b1;

      if (xfer) begin
         if (is_last) begin
            state_d = IDLE;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end

      // A load coinciding with the final transfer overrides the return to IDLE.
      if (accept) begin
         state_d = SEND;
         idx_d   = '0;
         buf_d   = q_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         buf_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ovf = ovf_q;

endmodule
